// File: rtl/ovl_one_hot_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter.
package ovl_one_hot_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam int MAX_WIDTH = 32;

  // Encoded index width, never narrower than one bit so width=1 still has a port.
  function automatic int idx_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_WIDTH-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ovl_rr_pick.sv
// Combinational round-robin pick: first unmasked request at or after ptr, wrapping.
module ovl_rr_pick
  import ovl_one_hot_pkg::*;
#(
  parameter int width = 4,
  parameter int iw    = idx_width(width)
) (
  input  logic [width-1:0] req,
  input  logic [iw-1:0]    ptr,
  input  logic [width-1:0] mask,
  output logic [width-1:0] winner,
  output logic             any
);

  logic [width-1:0] cand;
  logic [width-1:0] rot;
  logic [width-1:0] first;

  // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    cand   = req & ~mask;
    rot    = width'({cand, cand} >> ptr);
    first  = rot & (~rot + width'(1));
    winner = width'(({first, first} << ptr) >> width);
    any    = |cand;
  end

endmodule

// File: rtl/ovl_one_hot_rr_arbiter.sv
// Round-robin arbiter with a registered zero-or-one-hot grant held until release.
//   state | meaning
//   IDLE  | no grant outstanding
//   OWNED | one requester holds the grant
module ovl_one_hot_rr_arbiter
  import ovl_one_hot_pkg::*;
#(
  parameter int width = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [width-1:0]            req,
  input  logic                        done,
  input  logic                        clear_seen,
  output logic [width-1:0]            grant,
  output logic                        grant_valid,
  output logic [idx_width(width)-1:0] grant_idx,
  output logic [width-1:0]            grants_seen
);

  localparam int IW = idx_width(width);

  generate
    if (width < 1 || width > MAX_WIDTH) begin : g_bad_width
      $error("ovl_one_hot_rr_arbiter: width must be 1..32");
    end
  endgenerate

  state_t           state, state_next;
  logic [IW-1:0]    ptr, ptr_next, pick_ptr, owner_inc;
  logic [width-1:0] grant_next, pick_mask, winner;
  logic [IW-1:0]    idx_next;
  logic             any, release_now;

  assign owner_inc   = (grant_idx == IW'(width - 1)) ? '0 : grant_idx + IW'(1);
  assign release_now = (state == OWNED) && (done || ~|(req & grant));

  // While owned, the picker already looks past the owner so a release can hand off with no bubble.
  assign pick_ptr  = (state == OWNED) ? owner_inc : ptr;
  assign pick_mask = (state == OWNED) ? grant : '0;

  ovl_rr_pick #(.width(width), .iw(IW)) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .mask   (pick_mask),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    grant_next = grant;
    case (state)
      IDLE: begin
        if (enable && any) begin
          grant_next = winner;
          state_next = OWNED;
        end else begin
          grant_next = '0;
        end
      end
      OWNED: begin
        if (release_now) begin
          ptr_next = owner_inc;
          if (enable && any) begin
            grant_next = winner;
          end else begin
            grant_next = '0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
    idx_next = IW'(onehot_to_idx(MAX_WIDTH'(grant_next)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      grants_seen <= '0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      grant       <= grant_next;
      grant_valid <= |grant_next;
      grant_idx   <= idx_next;
      grants_seen <= clear_seen ? '0 : (grants_seen | grant_next);
    end
  end

endmodule

// File: doc/ovl_one_hot_rr_arbiter.md
Name: ovl_one_hot_rr_arbiter

Overview:
- Round-robin arbiter whose registered grant vector is always zero or one-hot. This is the producer-side counterpart of the one-hot checker.
- Grants one requester at a time and holds the grant until the owner releases it.
- Accumulates a sticky record of every grant bit issued (grants_seen), which feeds the one-hot checker's one_hots_checked coverage input.
- Sits between multiple bus masters and a shared resource; its grant output is the signal that the one-hot assertion binds to.

Parameters:
- width, 4, number of requesters; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when 0, no new grant is issued; an existing grant is unaffected.
- req  input  width  request vector; bit i = requester i.
- done  input  1  owner releases the grant; sampled only while grant_valid=1.
- clear_seen  input  1  synchronous clear of grants_seen.
- grant  output  width  registered grant; always 0 or exactly one bit set.
- grant_valid  output  1  registered; equals |grant.
- grant_idx  output  $clog2(width) (min 1)  encoded index of the current grant; 0 when no grant.
- grants_seen  output  width  sticky OR of all grants issued since reset or clear_seen.

Behaviour:
- All outputs and state are registered on the rising edge of clk.
- Reset (sampled at any cycle, including mid-grant) forces, next cycle:
  - grant=0, grant_valid=0, grant_idx=0, grants_seen=0.
  - Rotation pointer ptr=0, state IDLE.
- States:
  - IDLE: no grant.
  - OWNED: grant held.
- IDLE -> OWNED when enable=1 and |req=1.
  - Winner = first set req bit scanning ptr, ptr+1, ... width-1, 0, ... ptr-1 (wrap-around).
  - grant is one-hot of the winner in the following cycle: 1-cycle latency.
- OWNED, release:
  - Release = done=1, or req[owner]=0 (implicit release by the requester dropping its request).
  - On release, ptr <= (owner+1) mod width.
  - In the same cycle, re-arbitrate using the updated ptr over req with the owner bit masked.
  - If the re-arbitration has a winner and enable=1, go directly OWNED with the new grant next cycle (back-to-back, no bubble).
  - Otherwise go to IDLE: grant=0 next cycle.
  - A releasing owner that still requests is not re-granted in that cycle; it waits at least one arbitration.
- OWNED with no release: grant, grant_idx and ptr are held. Changes to enable or to other req bits have no effect.
- done while IDLE: ignored.
- width=1: grant=req[0] registered with release semantics; ptr stays 0.
- grants_seen:
  - Each cycle, grants_seen <= grants_seen | grant_next.
  - clear_seen=1 has priority: grants_seen <= 0, and the grant issued in that same cycle is not recorded.
  - reset has priority over clear_seen.
- Invariants:
  - $countones(grant) <= 1 every cycle.
  - grant_valid == (grant != 0).
  - grant_idx matches grant whenever grant_valid=1.
- Out-of-range width is caught by an elaboration-time check.

Decomposition:
- Package ovl_one_hot_pkg:
  - State enum {IDLE, OWNED}.
  - Function onehot_to_idx.
  - Localparam helper for index width (max(1, $clog2(width))).
- Sub-module ovl_rr_pick, purely combinational:
  - Inputs: req, ptr, mask.
  - Outputs: one-hot winner, any.
  - Implementation: double-width rotate-and-priority. Reused by the initial-grant and back-to-back paths.

Test Plan (width=4):
1. Reset, with req=4'b1111 and enable=1 during reset -> grant=0, grant_valid=0, grants_seen=0 every reset cycle; first grant 4'b0001 one cycle after reset deasserts.
2. From reset, req=4'b1010 -> grant=4'b0010, grant_idx=1 next cycle. Assert done for one cycle -> grant=4'b1000 on the next cycle with no bubble; grants_seen=4'b1010.
3. Fairness: req=4'b1111 held, done asserted every OWNED cycle -> grant sequence 0001, 0010, 0100, 1000, 0001; one-hot invariant holds throughout.
4. Implicit release: owner 2 (grant=4'b0100), drop req to 4'b0000 -> grant=0 next cycle, IDLE. Then req=4'b1001 -> grant=4'b1000 (ptr=3).
5. enable=0 with req=4'b0001 for 5 cycles -> grant=0 throughout. Raise enable -> grant=4'b0001 next cycle. Drop enable while owned -> grant held until done.
6. Reset mid-grant (grant=4'b0100) -> grant=0 next cycle, ptr=0. After grants_seen=4'b1011, pulse clear_seen while a grant of 4'b0100 is issued -> grants_seen=0 that cycle and 4'b0100 the following cycle.
